// File: rtl/controle_reproducao_m_pkg.sv
// Shared definitions for the melody player playback controller: state encoding and default
// debounce sizing.
package controle_reproducao_m_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        TOCANDO = 2'd1,
        PAUSADO = 2'd2
    } state_t;

    localparam int LP_DEBOUNCE_DEFAULT = 1_000_000;
    localparam int LP_CNT_W_DEFAULT    = 20;

    // Encoding 2'd3 is unused; the FSM treats it as a fault and recovers to OCIOSO.
    function automatic logic is_legal_state(input logic [1:0] s);
        return (s != 2'd3);
    endfunction

endpackage

// File: rtl/controle_reproducao_m_if.sv
// Board/sequencer-facing signals of the playback controller, with the controller on the
// slave side and the buttons/sequencer on the master side.
interface controle_reproducao_m_if;
    import controle_reproducao_m_pkg::*;

    logic play_btn;
    logic stop_btn;
    logic Fim_musica;
    logic Play_out;
    logic stop_out;
    logic Tocando;
    logic Pausado;

    modport master (
        output play_btn,
        output stop_btn,
        output Fim_musica,
        input  Play_out,
        input  stop_out,
        input  Tocando,
        input  Pausado
    );

    modport slave (
        input  play_btn,
        input  stop_btn,
        input  Fim_musica,
        output Play_out,
        output stop_out,
        output Tocando,
        output Pausado
    );

endinterface

// File: rtl/controle_reproducao_m_debounce.sv
// Push-button conditioner: 2-FF synchronizer, polarity normalisation, stability counter and a
// single-cycle registered pulse on each accepted press.
module debounce_m
    import controle_reproducao_m_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = LP_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = LP_CNT_W_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_check
        $error("debounce_m: DEBOUNCE_CYCLES must be >= 2 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; the synchronizer resets to it so no false edge follows reset.
    localparam logic LP_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pressed;

    assign w_pressed = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= LP_IDLE;
            r_sync2   <= LP_IDLE;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (w_pressed == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_level <= w_pressed;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/controle_reproducao_m.sv
// Playback control stage: debounces play/stop buttons and runs the OCIOSO/TOCANDO/PAUSADO
// state machine that drives the sequencer's Play_in level and stop_in pulse.
module controle_reproducao_m
    import controle_reproducao_m_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = LP_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = LP_CNT_W_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    controle_reproducao_m_if.slave      bus
);

    if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_check
        $error("controle_reproducao_m: DEBOUNCE_CYCLES must be >= 2 and DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
    end

    logic   w_press_play;
    logic   w_press_stop;
    state_t r_state;
    state_t w_state_next;
    logic   w_stop_next;
    logic   r_play_out;
    logic   r_stop_out;
    logic   r_tocando;
    logic   r_pausado;

    debounce_m #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb_play (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_btn   (bus.play_btn),
        .o_press (w_press_play)
    );

    debounce_m #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb_stop (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_btn   (bus.stop_btn),
        .o_press (w_press_stop)
    );

    // Priority: stop > end of song > play. A stop pulse is suppressed when the previous cycle
    // already issued one, so the sequencer never sees stop_in high on two consecutive cycles.
    always_comb begin
        w_state_next = r_state;
        w_stop_next  = 1'b0;
        if (!is_legal_state(r_state)) begin
            w_state_next = OCIOSO;
        end else if (w_press_stop) begin
            w_state_next = OCIOSO;
            w_stop_next  = ~r_stop_out;
        end else if (bus.Fim_musica && (r_state == TOCANDO)) begin
            w_state_next = OCIOSO;
            w_stop_next  = ~r_stop_out;
        end else if (w_press_play) begin
            case (r_state)
                OCIOSO:  w_state_next = TOCANDO;
                TOCANDO: w_state_next = PAUSADO;
                PAUSADO: w_state_next = TOCANDO;
                default: w_state_next = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= OCIOSO;
            r_play_out <= 1'b0;
            r_stop_out <= 1'b0;
            r_tocando  <= 1'b0;
            r_pausado  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_play_out <= (w_state_next == TOCANDO);
            r_stop_out <= w_stop_next;
            r_tocando  <= (w_state_next == TOCANDO);
            r_pausado  <= (w_state_next == PAUSADO);
        end
    end

    assign bus.Play_out = r_play_out;
    assign bus.stop_out = r_stop_out;
    assign bus.Tocando  = r_tocando;
    assign bus.Pausado  = r_pausado;

endmodule

// File: tb/tb_controle_reproducao_m.sv
// Directed bench for the playback controller with a 4-cycle debounce window.
module tb_controle_reproducao_m;
    import controle_reproducao_m_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    controle_reproducao_m_if bus_if ();

    controle_reproducao_m #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .BTN_ACTIVE_LOW  (1'b1)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if)
    );

    always #5 Clk = ~Clk;

    int n_checks    = 0;
    int n_fail      = 0;
    int stop_pulses = 0;
    int play_pulses = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus_if.stop_out === 1'b1) stop_pulses++;
            if (u_dut.w_press_play === 1'b1) play_pulses++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {bus_if.Play_out, bus_if.stop_out, bus_if.Tocando, bus_if.Pausado};
            n_checks++;
            if (outs !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 0000", i, outs);
            end
            n_checks++;
            if (u_dut.r_state !== OCIOSO) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %0d expected 0", i, u_dut.r_state);
            end
        end
        Reset = 1'b0;
        hold(3);
        outs = {bus_if.Play_out, bus_if.stop_out, bus_if.Tocando, bus_if.Pausado};
        n_checks++;
        if (outs !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_reset_idle: got %b expected 0000", outs);
        end
    endtask

    task automatic test_play_press();
        int pulses = 0;
        bus_if.play_btn = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (u_dut.w_press_play === 1'b1) pulses++;
            if (e == 7) begin
                n_checks++;
                if (u_dut.w_press_play !== 1'b1 || bus_if.Tocando !== 1'b0) begin
                    n_fail++;
                    $display("FAIL press_pulse_edge7: press=%b tocando=%b expected press=1 tocando=0",
                             u_dut.w_press_play, bus_if.Tocando);
                end
            end
            if (e == 8) begin
                n_checks++;
                if (bus_if.Play_out !== 1'b1 || bus_if.Tocando !== 1'b1 || bus_if.Pausado !== 1'b0) begin
                    n_fail++;
                    $display("FAIL play_edge8: play_out=%b tocando=%b pausado=%b expected 1 1 0",
                             bus_if.Play_out, bus_if.Tocando, bus_if.Pausado);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL single_press_event: got %0d pulses expected 1", pulses);
        end
        bus_if.play_btn = 1'b1;
        hold(8);
        n_checks++;
        if (bus_if.Tocando !== 1'b1 || bus_if.stop_out !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_event: tocando=%b stop_out=%b expected 1 0", bus_if.Tocando, bus_if.stop_out);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int pulse_edge = -1;
        for (int k = 0; k < 22; k++) begin
            if (k <= 12 && (k % 2) == 0) bus_if.play_btn = (((k / 2) % 2) == 1);
            tick();
            if (u_dut.w_press_play === 1'b1) begin
                pulses++;
                pulse_edge = k + 1;
            end
            if (k + 1 == 19) begin
                n_checks++;
                if (bus_if.Tocando !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_no_early_change: tocando=%b expected 1", bus_if.Tocando);
                end
            end
            if (k + 1 == 20) begin
                n_checks++;
                if (bus_if.Pausado !== 1'b1 || bus_if.Play_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_pause: pausado=%b play_out=%b expected 1 0",
                             bus_if.Pausado, bus_if.Play_out);
                end
            end
        end
        n_checks++;
        if (pulses != 1 || pulse_edge != 19) begin
            n_fail++;
            $display("FAIL bounce_single_press: got %0d pulses at edge %0d expected 1 at 19", pulses, pulse_edge);
        end
        bus_if.play_btn = 1'b1;
        hold(8);
    endtask

    task automatic test_pause_resume();
        stop_pulses = 0;
        bus_if.play_btn = 1'b0;
        hold(8);
        n_checks++;
        if (bus_if.Tocando !== 1'b1 || bus_if.Pausado !== 1'b0) begin
            n_fail++;
            $display("FAIL resume: tocando=%b pausado=%b expected 1 0", bus_if.Tocando, bus_if.Pausado);
        end
        bus_if.play_btn = 1'b1;
        hold(8);
        bus_if.play_btn = 1'b0;
        hold(8);
        n_checks++;
        if (bus_if.Pausado !== 1'b1 || bus_if.Play_out !== 1'b0 || bus_if.Tocando !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_again: pausado=%b play_out=%b tocando=%b expected 1 0 0",
                     bus_if.Pausado, bus_if.Play_out, bus_if.Tocando);
        end
        bus_if.play_btn = 1'b1;
        hold(8);
        n_checks++;
        if (stop_pulses != 0) begin
            n_fail++;
            $display("FAIL pause_no_stop: got %0d stop pulses expected 0", stop_pulses);
        end
    endtask

    task automatic test_simultaneous();
        stop_pulses = 0;
        bus_if.play_btn = 1'b0;
        bus_if.stop_btn = 1'b0;
        hold(7);
        n_checks++;
        if (bus_if.Pausado !== 1'b1 || bus_if.stop_out !== 1'b0) begin
            n_fail++;
            $display("FAIL simult_before: pausado=%b stop_out=%b expected 1 0", bus_if.Pausado, bus_if.stop_out);
        end
        hold(1);
        n_checks++;
        if (bus_if.stop_out !== 1'b1 || bus_if.Pausado !== 1'b0 || bus_if.Play_out !== 1'b0 ||
            u_dut.r_state !== OCIOSO) begin
            n_fail++;
            $display("FAIL simult_stop: stop_out=%b pausado=%b play_out=%b state=%0d expected 1 0 0 0",
                     bus_if.stop_out, bus_if.Pausado, bus_if.Play_out, u_dut.r_state);
        end
        hold(1);
        n_checks++;
        if (bus_if.stop_out !== 1'b0) begin
            n_fail++;
            $display("FAIL simult_stop_width: stop_out=%b expected 0", bus_if.stop_out);
        end
        bus_if.play_btn = 1'b1;
        bus_if.stop_btn = 1'b1;
        hold(10);
        n_checks++;
        if (stop_pulses != 1 || bus_if.Tocando !== 1'b0 || u_dut.r_state !== OCIOSO) begin
            n_fail++;
            $display("FAIL simult_play_dropped: stops=%0d tocando=%b state=%0d expected 1 0 0",
                     stop_pulses, bus_if.Tocando, u_dut.r_state);
        end
    endtask

    task automatic test_stop_idle();
        stop_pulses = 0;
        bus_if.stop_btn = 1'b0;
        hold(8);
        n_checks++;
        if (bus_if.stop_out !== 1'b1 || u_dut.r_state !== OCIOSO) begin
            n_fail++;
            $display("FAIL stop_in_idle: stop_out=%b state=%0d expected 1 0", bus_if.stop_out, u_dut.r_state);
        end
        bus_if.stop_btn = 1'b1;
        hold(8);
        n_checks++;
        if (stop_pulses != 1) begin
            n_fail++;
            $display("FAIL stop_idle_count: got %0d expected 1", stop_pulses);
        end
    endtask

    task automatic test_fim_musica();
        bus_if.play_btn = 1'b0;
        hold(8);
        bus_if.play_btn = 1'b1;
        hold(8);
        stop_pulses = 0;
        n_checks++;
        if (bus_if.Tocando !== 1'b1) begin
            n_fail++;
            $display("FAIL fim_setup: tocando=%b expected 1", bus_if.Tocando);
        end
        bus_if.Fim_musica = 1'b1;
        hold(1);
        bus_if.Fim_musica = 1'b0;
        n_checks++;
        if (bus_if.stop_out !== 1'b1 || bus_if.Tocando !== 1'b0 || u_dut.r_state !== OCIOSO) begin
            n_fail++;
            $display("FAIL fim_in_tocando: stop_out=%b tocando=%b state=%0d expected 1 0 0",
                     bus_if.stop_out, bus_if.Tocando, u_dut.r_state);
        end
        hold(1);
        bus_if.Fim_musica = 1'b1;
        hold(1);
        bus_if.Fim_musica = 1'b0;
        n_checks++;
        if (bus_if.stop_out !== 1'b0 || u_dut.r_state !== OCIOSO) begin
            n_fail++;
            $display("FAIL fim_in_ocioso: stop_out=%b state=%0d expected 0 0", bus_if.stop_out, u_dut.r_state);
        end
        hold(2);
        n_checks++;
        if (stop_pulses != 1) begin
            n_fail++;
            $display("FAIL fim_stop_count: got %0d expected 1", stop_pulses);
        end
    endtask

    task automatic test_reset_mid_debounce();
        bus_if.play_btn = 1'b0;
        hold(4);
        n_checks++;
        if (u_dut.u_deb_play.r_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_debounce_count: got %0d expected 2", u_dut.u_deb_play.r_cnt);
        end
        Reset = 1'b1;
        bus_if.play_btn = 1'b1;
        hold(2);
        n_checks++;
        if (u_dut.u_deb_play.r_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_clears_count: got %0d expected 0", u_dut.u_deb_play.r_cnt);
        end
        Reset = 1'b0;
        play_pulses = 0;
        hold(15);
        n_checks++;
        if (play_pulses != 0 || bus_if.Tocando !== 1'b0 || bus_if.Play_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discards_press: pulses=%0d tocando=%b play_out=%b expected 0 0 0",
                     play_pulses, bus_if.Tocando, bus_if.Play_out);
        end
    endtask

    initial begin
        bus_if.play_btn   = 1'b1;
        bus_if.stop_btn   = 1'b1;
        bus_if.Fim_musica = 1'b0;
        test_reset();
        test_play_press();
        test_bounce();
        test_pause_resume();
        test_simultaneous();
        test_stop_idle();
        test_fim_musica();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
